// File: rtl/lu_rs_ctrl_if.sv
// Signal bundle for lu_rs_ctrl: issue, CDB snoop, logic-unit and result paths.
// Handshake: a transfer completes on a rising edge where valid && ready are both 1;
// the source keeps valid and its payload stable while valid=1 and ready=0.
interface lu_rs_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_opcode;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_v1_ok;
    logic             issue_v2_ok;
    logic [31:0]      issue_v1;
    logic [31:0]      issue_v2;
    logic [TAG_W-1:0] issue_q1;
    logic [TAG_W-1:0] issue_q2;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic [31:0]      lu_x1;
    logic [31:0]      lu_x2;
    logic [2:0]       lu_opcode;
    logic [31:0]      lu_y;

    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;

    logic [CNT_W-1:0] busy_count;

    modport master (
        output issue_valid, issue_opcode, issue_tag, issue_v1_ok, issue_v2_ok,
        output issue_v1, issue_v2, issue_q1, issue_q2,
        output cdb_valid, cdb_tag, cdb_data,
        output lu_y, res_ready,
        input  issue_ready, lu_x1, lu_x2, lu_opcode,
        input  res_valid, res_tag, res_data, busy_count
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_tag, issue_v1_ok, issue_v2_ok,
        input  issue_v1, issue_v2, issue_q1, issue_q2,
        input  cdb_valid, cdb_tag, cdb_data,
        input  lu_y, res_ready,
        output issue_ready, lu_x1, lu_x2, lu_opcode,
        output res_valid, res_tag, res_data, busy_count
    );
endinterface

// File: rtl/lu_rs_ctrl.sv
// Reservation station feeding an external combinational logic unit, round-robin dispatch.
// Optional macro LU_RS_BYPASS_EN: CDB data captured this cycle may dispatch this cycle.
module lu_rs_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    lu_rs_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd6;

    logic             r_busy [DEPTH];
    logic [2:0]       r_op   [DEPTH];
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [31:0]      r_v1   [DEPTH];
    logic [31:0]      r_v2   [DEPTH];
    logic [TAG_W-1:0] r_q1   [DEPTH];
    logic [TAG_W-1:0] r_q2   [DEPTH];
    logic             r_rdy1 [DEPTH];
    logic             r_rdy2 [DEPTH];
    logic [IDX_W-1:0] r_rr;
    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [31:0]      r_res_data;

    logic [DEPTH-1:0] w_cap1;
    logic [DEPTH-1:0] w_cap2;
    logic [DEPTH-1:0] w_disp_ok;
    logic [IDX_W-1:0] w_cand [DEPTH];
    logic             w_any_free;
    logic [IDX_W-1:0] w_free_idx;
    logic [CNT_W-1:0] w_busy_count;
    logic             w_any_disp;
    logic             w_dispatch;
    logic [IDX_W-1:0] w_sel;
    logic [31:0]      w_x1;
    logic [31:0]      w_x2;
    logic             w_issue_fire;
    logic             w_iss_cap1;
    logic             w_iss_cap2;
    logic             w_iss_unary;

    // Free-slot search and occupancy use registered busy bits only, so an entry
    // freed by this cycle's dispatch is not visible to the issue side until next cycle.
    always_comb begin
        w_any_free   = 1'b0;
        w_free_idx   = '0;
        w_busy_count = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            w_busy_count = w_busy_count + CNT_W'(r_busy[i]);
        end
    end

    always_comb begin
        w_cap1    = '0;
        w_cap2    = '0;
        w_disp_ok = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cap1[i] = r_busy[i] && !r_rdy1[i] && bus.cdb_valid && (r_q1[i] == bus.cdb_tag);
            w_cap2[i] = r_busy[i] && !r_rdy2[i] && bus.cdb_valid && (r_q2[i] == bus.cdb_tag);
`ifdef LU_RS_BYPASS_EN
            w_disp_ok[i] = r_busy[i] && (r_rdy1[i] || w_cap1[i]) && (r_rdy2[i] || w_cap2[i]);
`else
            w_disp_ok[i] = r_busy[i] && r_rdy1[i] && r_rdy2[i];
`endif
        end
    end

    // Candidate k is the k-th index visited starting from the round-robin pointer.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_cand[k] = IDX_W'((int'(r_rr) + k) % DEPTH);
        end
    end

    always_comb begin
        w_any_disp = 1'b0;
        w_sel      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_disp_ok[w_cand[k]]) begin
                w_any_disp = 1'b1;
                w_sel      = w_cand[k];
            end
        end
    end

    always_comb begin
`ifdef LU_RS_BYPASS_EN
        w_x1 = w_cap1[w_sel] ? bus.cdb_data : r_v1[w_sel];
        w_x2 = w_cap2[w_sel] ? bus.cdb_data : r_v2[w_sel];
`else
        w_x1 = r_v1[w_sel];
        w_x2 = r_v2[w_sel];
`endif
    end

    assign w_dispatch   = w_any_disp && (!r_res_valid || bus.res_ready);
    assign w_issue_fire = bus.issue_valid && w_any_free;
    assign w_iss_cap1   = !bus.issue_v1_ok && bus.cdb_valid && (bus.issue_q1 == bus.cdb_tag);
    assign w_iss_cap2   = !bus.issue_v2_ok && bus.cdb_valid && (bus.issue_q2 == bus.cdb_tag);
    assign w_iss_unary  = (bus.issue_opcode == OP_NOT) || (bus.issue_opcode == OP_NEG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_rdy1[i] <= 1'b0;
                r_rdy2[i] <= 1'b0;
            end
            r_rr        <= '0;
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cap1[i]) begin
                    r_v1[i]   <= bus.cdb_data;
                    r_rdy1[i] <= 1'b1;
                end
                if (w_cap2[i]) begin
                    r_v2[i]   <= bus.cdb_data;
                    r_rdy2[i] <= 1'b1;
                end
            end
            if (w_dispatch) begin
                r_busy[w_sel] <= 1'b0;
                r_res_valid   <= 1'b1;
                r_res_tag     <= r_tag[w_sel];
                r_res_data    <= bus.lu_y;
                r_rr          <= (w_sel == IDX_W'(DEPTH - 1)) ? '0 : w_sel + IDX_W'(1);
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
            // Unary ops never wait on operand 2; its stored value is don't-care.
            if (w_issue_fire) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= bus.issue_opcode;
                r_tag[w_free_idx]  <= bus.issue_tag;
                r_v1[w_free_idx]   <= bus.issue_v1_ok ? bus.issue_v1 : bus.cdb_data;
                r_q1[w_free_idx]   <= bus.issue_q1;
                r_rdy1[w_free_idx] <= bus.issue_v1_ok || w_iss_cap1;
                r_v2[w_free_idx]   <= bus.issue_v2_ok ? bus.issue_v2 : bus.cdb_data;
                r_q2[w_free_idx]   <= bus.issue_q2;
                r_rdy2[w_free_idx] <= bus.issue_v2_ok || w_iss_unary || w_iss_cap2;
            end
        end
    end

    assign bus.issue_ready = w_any_free;
    assign bus.busy_count  = w_busy_count;
    assign bus.lu_x1       = w_dispatch ? w_x1 : 32'd0;
    assign bus.lu_x2       = w_dispatch ? w_x2 : 32'd0;
    assign bus.lu_opcode   = w_dispatch ? r_op[w_sel] : 3'd0;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_tag     = r_res_tag;
    assign bus.res_data    = r_res_data;
endmodule
